// File: rtl/note_seq_pkg.sv
// rtl/note_seq_pkg.sv - shared state encoding, end marker and ROM field layout for note_sequencer
package note_seq_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_FETCH,
      S_DECODE,
      S_LOAD,
      S_WAIT_CLR,
      S_WAIT_DONE,
      S_ENDED
   } state_t;

   localparam logic [11:0] END_MARKER = 12'h000;

   // ROM word layout: {note[11:6], duration[5:0]}
   localparam int NOTE_LSB = 6;
   localparam int NOTE_W   = 6;
   localparam int DUR_LSB  = 0;
   localparam int DUR_W    = 6;

endpackage

// File: rtl/note_sequencer.sv
// rtl/note_sequencer.sv - song ROM walker feeding an external note player
// Optional macro NOTE_SEQ_LOOP_EN: end marker loops the song instead of ending it.
module note_sequencer
   import note_seq_pkg::*;
#(
   parameter int ADDR_W = 7,
   parameter int SONG_W = 2
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     play,
   input  logic [SONG_W-1:0]        song_sel,
   input  logic                     restart,
   output logic [SONG_W+ADDR_W-1:0] rom_addr,
   input  logic [11:0]              rom_data,
   output logic [NOTE_W-1:0]        note_to_load,
   output logic [DUR_W-1:0]         duration_to_load,
   output logic                     load_new_note,
   input  logic                     done_with_note,
   output logic                     play_enable,
   output logic                     song_done
);

   state_t              r_state;
   logic [ADDR_W-1:0]   r_index;
   logic [SONG_W-1:0]   r_song;
   logic [NOTE_W-1:0]   r_note;
   logic [DUR_W-1:0]    r_dur;
   logic                r_load;
   logic                r_play_enable;
   logic                r_song_done;

   logic                w_end_marker;

   assign w_end_marker = (rom_data == END_MARKER);

   always_ff @(posedge clk) begin
      if (!reset) begin
         r_state       <= S_IDLE;
         r_index       <= '0;
         r_song        <= '0;
         r_note        <= '0;
         r_dur         <= '0;
         r_load        <= 1'b0;
         r_play_enable <= 1'b0;
         r_song_done   <= 1'b0;
      end else begin
         r_load        <= 1'b0;
         r_play_enable <= play;
         if (restart) begin
            // Restart wins over everything, including a strobe LOAD was about to issue.
            r_index     <= '0;
            r_song      <= song_sel;
            r_song_done <= 1'b0;
            r_state     <= S_FETCH;
         end else begin
            case (r_state)
               S_IDLE: begin
                  if (play) begin
                     r_index <= '0;
                     r_song  <= song_sel;
                     r_state <= S_FETCH;
                  end
               end
               S_FETCH: begin
                  if (play) r_state <= S_DECODE;
               end
               S_DECODE: begin
                  if (play) begin
                     if (w_end_marker) begin
`ifdef NOTE_SEQ_LOOP_EN
                        r_index <= '0;
                        r_state <= S_FETCH;
`else
                        r_song_done   <= 1'b1;
                        r_play_enable <= 1'b0;
                        r_state       <= S_ENDED;
`endif
                     end else begin
                        r_note  <= rom_data[NOTE_LSB +: NOTE_W];
                        r_dur   <= rom_data[DUR_LSB +: DUR_W];
                        r_state <= S_LOAD;
                     end
                  end
               end
               S_LOAD: begin
                  if (play) begin
                     r_load  <= 1'b1;
                     r_state <= S_WAIT_CLR;
                  end
               end
               // The player may still show done from the previous note; wait for it to drop.
               S_WAIT_CLR: begin
                  if (!done_with_note) r_state <= S_WAIT_DONE;
               end
               S_WAIT_DONE: begin
                  if (done_with_note) begin
                     r_index <= r_index + ADDR_W'(1);
                     r_state <= S_FETCH;
                  end
               end
               S_ENDED: begin
                  r_play_enable <= 1'b0;
               end
               default: r_state <= S_IDLE;
            endcase
         end
      end
   end

   assign rom_addr         = {r_song, r_index};
   assign note_to_load     = r_note;
   assign duration_to_load = r_dur;
   assign load_new_note    = r_load;
   assign play_enable      = r_play_enable;
   assign song_done        = r_song_done;

endmodule

// File: tb/tb_note_sequencer.sv
// tb/tb_note_sequencer.sv - directed vector bench for note_sequencer with a behavioural song ROM
module tb_note_sequencer;

   localparam int ADDR_W = 7;
   localparam int SONG_W = 2;

   logic        clk = 1'b0;
   logic        reset;
   logic        play;
   logic [1:0]  song_sel;
   logic        restart;
   logic [8:0]  rom_addr;
   logic [11:0] rom_data = '0;
   logic [5:0]  note_to_load;
   logic [5:0]  duration_to_load;
   logic        load_new_note;
   logic        done_with_note;
   logic        play_enable;
   logic        song_done;

   logic [11:0] rom [0:511];

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   always @(posedge clk) rom_data <= rom[rom_addr];

   note_sequencer #(.ADDR_W(ADDR_W), .SONG_W(SONG_W)) dut (
      .clk              (clk),
      .reset            (reset),
      .play             (play),
      .song_sel         (song_sel),
      .restart          (restart),
      .rom_addr         (rom_addr),
      .rom_data         (rom_data),
      .note_to_load     (note_to_load),
      .duration_to_load (duration_to_load),
      .load_new_note    (load_new_note),
      .done_with_note   (done_with_note),
      .play_enable      (play_enable),
      .song_done        (song_done)
   );

   typedef struct {
      logic       play;
      logic       restart;
      logic [1:0] sel;
      logic       done;
      logic       load;
      logic [5:0] note;
      logic [5:0] dur;
      logic [8:0] addr;
      logic       pe;
      logic       sd;
   } vec_t;

   vec_t vecs[$];

   function automatic vec_t mk(logic p, logic r, logic [1:0] s, logic d,
                               logic l, logic [5:0] n, logic [5:0] du,
                               logic [8:0] a, logic pe, logic sd);
      vec_t v;
      v.play = p; v.restart = r; v.sel = s; v.done = d;
      v.load = l; v.note = n; v.dur = du; v.addr = a; v.pe = pe; v.sd = sd;
      return v;
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic wait_load(output bit seen);
      seen = 1'b0;
      for (int i = 0; i < 60; i++) begin
         step();
         if (load_new_note) begin
            seen = 1'b1;
            break;
         end
      end
   endtask

   // Player handshake from WAIT_CLR: done low one cycle, pulse high, leaves FSM in FETCH.
   task automatic finish_note();
      done_with_note = 1'b0;
      step();
      done_with_note = 1'b1;
      step();
      done_with_note = 1'b0;
   endtask

   initial begin
      bit seen;
      vec_t v;

      for (int i = 0; i < 512; i++) rom[i] = 12'h000;
      rom[0]   = {6'd12, 6'd3};
      rom[1]   = {6'd20, 6'd2};
      rom[256] = {6'd7,  6'd5};
      rom[257] = {6'd0,  6'd9};
      for (int i = 0; i < 128; i++) rom[128 + i] = {6'((i % 63) + 1), 6'd1};
      rom[384] = {6'd5, 6'd1};

      // play, restart, sel, done | load, note, dur, addr, play_enable, song_done
      vecs.push_back(mk(1,0,0,0, 0, 0,0,  0,1,0));
      vecs.push_back(mk(1,0,0,0, 0, 0,0,  0,1,0));
      vecs.push_back(mk(1,0,0,0, 0,12,3,  0,1,0));
      vecs.push_back(mk(1,0,0,0, 1,12,3,  0,1,0));
      vecs.push_back(mk(1,0,0,0, 0,12,3,  0,1,0));
      vecs.push_back(mk(1,0,0,0, 0,12,3,  0,1,0));
      vecs.push_back(mk(1,0,0,1, 0,12,3,  1,1,0));
      vecs.push_back(mk(1,0,0,0, 0,12,3,  1,1,0));
      vecs.push_back(mk(1,0,0,0, 0,20,2,  1,1,0));
      vecs.push_back(mk(1,0,0,0, 1,20,2,  1,1,0));
      for (int i = 0; i < 5; i++)
         vecs.push_back(mk(1,0,0,1, 0,20,2,  1,1,0));
      vecs.push_back(mk(1,0,0,0, 0,20,2,  1,1,0));
      vecs.push_back(mk(1,0,0,1, 0,20,2,  2,1,0));
      vecs.push_back(mk(1,0,0,1, 0,20,2,  2,1,0));
      vecs.push_back(mk(1,0,0,0, 0,20,2,  2,0,1));
      vecs.push_back(mk(0,0,0,0, 0,20,2,  2,0,1));
      vecs.push_back(mk(1,0,0,0, 0,20,2,  2,0,1));
      vecs.push_back(mk(1,1,2,0, 0,20,2,256,1,0));
      vecs.push_back(mk(1,0,1,0, 0,20,2,256,1,0));
      vecs.push_back(mk(1,0,1,0, 0, 7,5,256,1,0));
      vecs.push_back(mk(1,0,1,0, 1, 7,5,256,1,0));
      vecs.push_back(mk(1,0,1,0, 0, 7,5,256,1,0));
      vecs.push_back(mk(1,0,1,1, 0, 7,5,257,1,0));
      vecs.push_back(mk(1,0,1,0, 0, 7,5,257,1,0));
      vecs.push_back(mk(1,0,1,0, 0, 0,9,257,1,0));
      vecs.push_back(mk(1,0,1,0, 1, 0,9,257,1,0));
      vecs.push_back(mk(1,0,1,0, 0, 0,9,257,1,0));
      vecs.push_back(mk(1,1,2,0, 0, 0,9,256,1,0));
      for (int i = 0; i < 10; i++)
         vecs.push_back(mk(0,0,2,0, 0, 0,9,256,0,0));
      vecs.push_back(mk(1,0,2,0, 0, 0,9,256,1,0));
      vecs.push_back(mk(1,0,2,0, 0, 7,5,256,1,0));
      vecs.push_back(mk(0,0,2,0, 0, 7,5,256,0,0));
      vecs.push_back(mk(1,0,2,0, 1, 7,5,256,1,0));
      vecs.push_back(mk(1,0,2,0, 0, 7,5,256,1,0));
      vecs.push_back(mk(1,0,2,1, 0, 7,5,257,1,0));
      vecs.push_back(mk(1,0,2,0, 0, 7,5,257,1,0));
      vecs.push_back(mk(1,0,2,0, 0, 0,9,257,1,0));
      vecs.push_back(mk(1,1,0,0, 0, 0,9,  0,1,0));
      vecs.push_back(mk(1,0,0,0, 0, 0,9,  0,1,0));
      vecs.push_back(mk(1,0,0,0, 0,12,3,  0,1,0));
      vecs.push_back(mk(1,0,0,0, 1,12,3,  0,1,0));

      reset = 1'b0; play = 1'b1; restart = 1'b0; song_sel = 2'd3; done_with_note = 1'b0;
      step();
      step();
      check("reset_outputs",
            32'({rom_addr, note_to_load, duration_to_load, load_new_note, play_enable, song_done}), 32'd0);

      reset = 1'b1;
      foreach (vecs[i]) begin
         v = vecs[i];
         play = v.play; restart = v.restart; song_sel = v.sel; done_with_note = v.done;
         step();
         n_cmp++;
         if ({load_new_note, note_to_load, duration_to_load, rom_addr, play_enable, song_done} !==
             {v.load, v.note, v.dur, v.addr, v.pe, v.sd}) begin
            n_bad++;
            $display("FAIL vec%0d: got load=%0d note=%0d dur=%0d addr=%0d pe=%0d sd=%0d expected load=%0d note=%0d dur=%0d addr=%0d pe=%0d sd=%0d",
                     i, load_new_note, note_to_load, duration_to_load, rom_addr, play_enable, song_done,
                     v.load, v.note, v.dur, v.addr, v.pe, v.sd);
         end
      end

      // Song 1: 128 entries, no marker; index must wrap and keep loading.
      play = 1'b1; song_sel = 2'd1; restart = 1'b1; done_with_note = 1'b0;
      step();
      restart = 1'b0;
      for (int k = 0; k < 130; k++) begin
         wait_load(seen);
         check($sformatf("wrap_load_seen_%0d", k), 32'(seen), 32'd1);
         if (!seen) break;
         check($sformatf("wrap_entry_%0d", k),
               32'({rom_addr, note_to_load, duration_to_load}),
               32'({9'(128 + (k % 128)), 6'(((k % 128) % 63) + 1), 6'd1}));
         finish_note();
      end
      check("wrap_song_done", 32'(song_done), 32'd0);

      // Song 3: {(5,1), end}.
      song_sel = 2'd3; restart = 1'b1;
      step();
      restart = 1'b0;
`ifdef NOTE_SEQ_LOOP_EN
      for (int r = 0; r < 3; r++) begin
         wait_load(seen);
         check($sformatf("loop_load_seen_%0d", r), 32'(seen), 32'd1);
         check($sformatf("loop_entry_%0d", r),
               32'({rom_addr, note_to_load, duration_to_load, song_done}),
               32'({9'd384, 6'd5, 6'd1, 1'b0}));
         finish_note();
      end
`else
      wait_load(seen);
      check("end_load_seen", 32'(seen), 32'd1);
      check("end_entry", 32'({rom_addr, note_to_load, duration_to_load}),
            32'({9'd384, 6'd5, 6'd1}));
      finish_note();
      step();
      step();
      check("ended_flags", 32'({song_done, play_enable}), 32'({1'b1, 1'b0}));
      play = 1'b0;
      step();
      play = 1'b1;
      step();
      step();
      check("ended_sticky", 32'({song_done, play_enable, load_new_note}), 32'({1'b1, 1'b0, 1'b0}));
`endif

      // Reset in the cycle LOAD would strobe: no strobe, all outputs cleared.
      song_sel = 2'd0; restart = 1'b1;
      step();
      restart = 1'b0;
      step();
      step();
      check("pre_reset_no_strobe", 32'(load_new_note), 32'd0);
      reset = 1'b0;
      step();
      reset = 1'b1; play = 1'b0;
      check("reset_mid_note", 32'({rom_addr, note_to_load, duration_to_load, load_new_note, play_enable, song_done}), 32'd0);
      step();
      check("after_release", 32'({load_new_note, rom_addr}), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/note_sequencer.md
NOTE_SEQUENCER -- requirements
Module: note_sequencer

Interface
REQ-001 SHALL have parameter ADDR_W, default 7, meaning note-address bits per song (128 entries).
REQ-002 SHALL have parameter SONG_W, default 2, meaning song-select bits (4 songs).
REQ-003 SHALL have port clk  input  1  system clock; all logic on rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-low reset.
REQ-005 SHALL have port play  input  1  level; 1 = run, 0 = pause.
REQ-006 SHALL have port song_sel  input  SONG_W  song to play, sampled only at start/restart.
REQ-007 SHALL have port restart  input  1  one-cycle pulse; restart the selected song from entry 0.
REQ-008 SHALL have port rom_addr  output  SONG_W+ADDR_W  song ROM address {song, index}.
REQ-009 SHALL have port rom_data  input  12  {note[11:6], duration[5:0]}, valid one cycle after rom_addr.
REQ-010 SHALL have port note_to_load  output  6  note code to the note player.
REQ-011 SHALL have port duration_to_load  output  6  duration in 1/48 s beats.
REQ-012 SHALL have port load_new_note  output  1  one-cycle load strobe.
REQ-013 SHALL have port done_with_note  input  1  note player finished the current note.
REQ-014 SHALL have port play_enable  output  1  gates the note player.
REQ-015 SHALL have port song_done  output  1  level; end-of-song reached and not restarted.

Function
REQ-016 SHALL implement states IDLE, FETCH, DECODE, LOAD, WAIT_CLR, WAIT_DONE, ENDED.
REQ-017 IDLE->FETCH when play=1 or restart=1; index<=0, song register<=song_sel.
REQ-018 FETCH drives rom_addr for exactly one cycle, then -> DECODE.
REQ-019 DECODE: rom_data==12'h000 is end-of-song -> ENDED; otherwise capture note/duration into output registers -> LOAD.
REQ-020 Note 0 with nonzero duration is a rest and SHALL be loaded like any note.
REQ-021 LOAD asserts load_new_note for exactly one cycle, -> WAIT_CLR.
REQ-022 WAIT_CLR waits for done_with_note==0 (stale done from the previous note), then -> WAIT_DONE.
REQ-023 WAIT_DONE waits for done_with_note==1; index increments mod 2^ADDR_W; -> FETCH.
REQ-024 Index wrap from 2^ADDR_W-1 to 0 with no end marker SHALL continue playing from entry 0.
REQ-025 play_enable SHALL be a register equal to play, delayed one cycle; 0 in IDLE and ENDED.
REQ-026 While play=0, the FSM SHALL hold in FETCH, DECODE and LOAD (no advance, no strobe); WAIT_CLR/WAIT_DONE continue, since the note timer is paused through play_enable.
REQ-027 restart SHALL take priority over every other event in any state: index<=0, song<=song_sel, song_done<=0, -> FETCH next cycle.
REQ-028 restart in the cycle LOAD would strobe SHALL suppress that strobe.
REQ-029 note_to_load/duration_to_load SHALL hold their value from DECODE until the next DECODE.
REQ-030 ENDED asserts song_done, stays until restart; play toggling SHALL NOT leave ENDED.
REQ-031 Note-to-note gap: load to next load = note time + 4 cycles minimum (FETCH, DECODE, LOAD, WAIT_DONE exit).

Reset
REQ-032 When reset=0 at a clock edge: state=IDLE, index=0, song=0, note/duration outputs=0, load_new_note=0, play_enable=0, song_done=0, rom_addr=0.
REQ-033 Reset mid-note SHALL abort with no load strobe in the cycle after release.

Configuration
REQ-034 Macro NOTE_SEQ_LOOP_EN: defined -> end-of-song marker restarts at index 0 of the same song (no ENDED, song_done stays 0); undefined -> behaviour of REQ-030.

Structure
REQ-035 Shared package note_seq_pkg SHALL hold the state enum, the end-marker constant 12'h000 and the ROM field offsets.
REQ-036 No sub-module; the song ROM and the note player SHALL be external instances wired at the top level.

Verification
REQ-037 ROM song 0 = {(12,3),(20,2),(0,0)}, play=1 -> two load strobes with (12,3) then (20,2); song_done=1 after second done.
REQ-038 Hold done_with_note=1 for 5 cycles after LOAD -> no FETCH until done falls and rises again.
REQ-039 play=0 in FETCH for 10 cycles -> rom_addr constant, no load strobe, play_enable=0 one cycle after play falls.
REQ-040 restart with song_sel=2 during WAIT_DONE -> next rom_addr={2,0}, song_done=0, no stale strobe.
REQ-041 Song with 128 entries and no marker -> index wraps 127->0; loads continue.
REQ-042 NOTE_SEQ_LOOP_EN defined, song {(5,1),(0,0)} -> (5,1) reloaded repeatedly, song_done never 1.
